// File: rtl/mole_game_pkg.sv
// mole_game_pkg: shared state type, lifetime table and widths for the whack-a-mole sequencer
package mole_game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam int SCORE_W = 10;
  localparam int LIFE_W = 11;
  localparam logic [LIFE_W-1:0] LIFETIME_MS [4] = '{11'd1500, 11'd1000, 11'd700, 11'd400};
endpackage

// File: rtl/mole_slot.sv
// mole_slot: one mole position with its own lifetime counter and hit/expiry pulses
module mole_slot
  import mole_game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              tick,
  input  logic              spawn,
  input  logic              hit_edge,
  input  logic [LIFE_W-1:0] lifetime,
  output logic              up,
  output logic              hit_pulse,
  output logic              expire_pulse
);
  logic [LIFE_W-1:0] cnt;
  logic last;
  assign last = up && tick && cnt == LIFE_W'(1);
  // a hit beats a same-cycle expiry; a spawn only lands on an empty slot
  always_ff @(posedge clk) begin
    if (reset || init) begin
      up <= 1'b0;
      cnt <= '0;
      hit_pulse <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      hit_pulse <= up && hit_edge;
      expire_pulse <= last && !hit_edge;
      up <= up ? !(hit_edge || last) : spawn;
      cnt <= !up ? (spawn ? lifetime : cnt) : (tick ? cnt - 1'b1 : cnt);
    end
  end
endmodule

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: game FSM, ms prescaler, game clock and score; MISS_PENALTY_EN penalises edges on empty slots
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int NUM_MOLES = 18,
  parameter int CLKS_PER_MS = 50000,
  parameter int GAME_MS = 30000,
  parameter int SCORE_MAX = 999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [1:0]           level,
  input  logic                 spawn_req,
  input  logic [4:0]           spawn_idx,
  input  logic [NUM_MOLES-1:0] switches,
  output logic [NUM_MOLES-1:0] ledr,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit,
  output logic                 expired,
  output logic [1:0]           state,
  output logic [5:0]           time_left_s
);
  localparam int PW = $clog2(CLKS_PER_MS + 1);
  localparam int GW = $clog2(GAME_MS + 1);
  state_t st;
  logic [PW-1:0] pre;
  logic [GW-1:0] game_cnt;
  logic [LIFE_W-1:0] life;
  logic [NUM_MOLES-1:0] hist, edges, hits, misses, hit_p, exp_p;
  logic play, tick, game_end, run;
  int sum;
  logic [SCORE_W-1:0] score_nx;
  assign play = st == PLAY;
  assign tick = play && pre == PW'(CLKS_PER_MS - 1);
  assign game_end = tick && game_cnt == GW'(1);
  assign run = play && !restart && !game_end;
  assign edges = run ? switches & ~hist : '0;
  assign hits = edges & ledr;
`ifdef MISS_PENALTY_EN
  assign misses = edges & ~ledr;
`else
  assign misses = '0;
`endif
  assign state = st;
  assign hit = |hit_p;
  assign expired = |exp_p;
  assign time_left_s = 6'(32'(game_cnt) / 32'd1000);
  // next score: hits minus misses, clamped to 0..SCORE_MAX
  always_comb begin
    sum = int'(score) + $countones(hits) - $countones(misses);
    score_nx = sum > SCORE_MAX ? SCORE_W'(SCORE_MAX) : sum < 0 ? '0 : SCORE_W'(sum);
  end
  // game FSM with prescaler, game counter, score and switch history
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      pre <= '0;
      game_cnt <= '0;
      score <= '0;
      life <= '0;
      hist <= '0;
    end else begin
      hist <= switches;
      pre <= (!play || restart || tick) ? '0 : pre + 1'b1;
      if (restart) begin
        st <= PLAY;
        game_cnt <= GW'(GAME_MS);
        score <= '0;
        life <= LIFETIME_MS[level];
      end else if (play) begin
        score <= score_nx;
        game_cnt <= tick ? game_cnt - 1'b1 : game_cnt;
        st <= game_end ? OVER : PLAY;
      end
    end
  end
  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_slot
    mole_slot u_slot (
      .clk(clk),
      .reset(reset),
      .init(!run),
      .tick(tick),
      .spawn(spawn_req && spawn_idx == 5'(i)),
      .hit_edge(edges[i]),
      .lifetime(life),
      .up(ledr[i]),
      .hit_pulse(hit_p[i]),
      .expire_pulse(exp_p[i])
    );
  end
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_mole_game_ctrl;
  localparam int N = 18;
  localparam int F_LEDR = 0, F_SCORE = 1, F_STATE = 2, F_TLS = 3, F_HIT = 4, F_EXP = 5, F_HCNT = 6, F_ECNT = 7;
`ifdef MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  typedef struct {int cyc; int fld; int val;} exp_t;
  exp_t q[$];
  logic clk = 0, reset = 1, restart = 0, spawn_req = 0;
  logic [1:0] level = 0;
  logic [4:0] spawn_idx = 0;
  logic [N-1:0] switches = 0;
  logic [N-1:0] ledr;
  logic [9:0] score;
  logic hit, expired;
  logic [1:0] state;
  logic [5:0] time_left_s;
  int cyc = 0, hcnt = 0, ecnt = 0, n_chk = 0, n_fail = 0, e;
  string nm [8] = '{"ledr", "score", "state", "time_left_s", "hit", "expired", "hit_count", "expired_count"};

  mole_game_ctrl #(.NUM_MOLES(N), .CLKS_PER_MS(4), .GAME_MS(3000), .SCORE_MAX(999)) dut (
    .clk(clk), .reset(reset), .restart(restart), .level(level), .spawn_req(spawn_req),
    .spawn_idx(spawn_idx), .switches(switches), .ledr(ledr), .score(score), .hit(hit),
    .expired(expired), .state(state), .time_left_s(time_left_s)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int dv(int f);
    return f == F_LEDR ? int'(ledr) : f == F_SCORE ? int'(score) : f == F_STATE ? int'(state) :
           f == F_TLS ? int'(time_left_s) : f == F_HIT ? int'(hit) : f == F_EXP ? int'(expired) :
           f == F_HCNT ? hcnt : ecnt;
  endfunction

  initial forever begin
    @(negedge clk);
    hcnt += int'(hit);
    ecnt += int'(expired);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_chk++;
        if (dv(q[i].fld) != q[i].val) begin
          n_fail++;
          $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", nm[q[i].fld], cyc, dv(q[i].fld), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic tic(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ex(int c, int f, int v);
    q.push_back('{c, f, v});
  endtask
  task automatic wait_to(int c);
    while (cyc < c) tic(1);
  endtask
  task automatic rs(int lv);
    level = 2'(lv);
    restart = 1;
    tic(1);
    restart = 0;
  endtask
  task automatic sp(int idx);
    spawn_idx = 5'(idx);
    spawn_req = 1;
    tic(1);
    spawn_req = 0;
  endtask

  initial begin
    tic(3);
    ex(cyc, F_STATE, 0); ex(cyc, F_LEDR, 0); ex(cyc, F_SCORE, 0);
    ex(cyc, F_TLS, 0); ex(cyc, F_HIT, 0); ex(cyc, F_EXP, 0);
    tic(1);
    reset = 0;
    tic(1);
    // level 0: spawn slot 5 and let it time out after 1500 ticks
    rs(0); e = cyc;
    ex(e, F_STATE, 1); ex(e, F_TLS, 3); ex(e, F_SCORE, 0); ex(e + 1, F_LEDR, 'h20);
    sp(5);
    ex(e + 5999, F_LEDR, 'h20); ex(e + 6000, F_LEDR, 0); ex(e + 6000, F_EXP, 1); ex(e + 6000, F_TLS, 1);
    ex(e + 6001, F_EXP, 0); ex(e + 6001, F_ECNT, 1); ex(e + 6001, F_SCORE, 0);
    wait_to(e + 6002);
    // level 3: respawn while up does not reload, then a hit
    rs(3); e = cyc;
    sp(2);
    wait_to(e + 800);
    sp(2);
    ex(e + 1599, F_LEDR, 'h4); ex(e + 1600, F_LEDR, 0); ex(e + 1600, F_EXP, 1); ex(e + 1601, F_ECNT, 2);
    wait_to(e + 1699);
    sp(2);
    wait_to(e + 2100);
    ex(e + 2100, F_LEDR, 'h4);
    switches[2] = 1;
    ex(e + 2101, F_LEDR, 0); ex(e + 2101, F_HIT, 1); ex(e + 2101, F_SCORE, 1);
    ex(e + 2102, F_HIT, 0); ex(e + 2102, F_HCNT, 1);
    wait_to(e + 2102);
    switches[2] = 0;
    // switch already high at restart is not an edge
    switches[7] = 1;
    rs(1); e = cyc;
    ex(e, F_SCORE, 0);
    sp(7);
    wait_to(e + 10);
    ex(e + 10, F_LEDR, 'h80); ex(e + 10, F_SCORE, 0); ex(e + 10, F_HCNT, 1);
    switches[7] = 0;
    wait_to(e + 12);
    switches[7] = 1;
    ex(e + 13, F_LEDR, 0); ex(e + 13, F_SCORE, 1); ex(e + 14, F_HCNT, 2);
    wait_to(e + 14);
    // double hit, then same-cycle hit and expiry on slot 0
    rs(3); e = cyc;
    ex(e, F_SCORE, 0);
    sp(0); sp(1); sp(3);
    wait_to(e + 100);
    switches[1] = 1; switches[3] = 1;
    ex(e + 101, F_LEDR, 'h1); ex(e + 101, F_SCORE, 2); ex(e + 101, F_HIT, 1); ex(e + 102, F_HCNT, 3);
    wait_to(e + 1599);
    switches[0] = 1;
    ex(e + 1600, F_LEDR, 0); ex(e + 1600, F_HIT, 1); ex(e + 1600, F_EXP, 0); ex(e + 1600, F_SCORE, 3);
    ex(e + 1601, F_ECNT, 2); ex(e + 1601, F_HCNT, 4);
    wait_to(e + 1601);
    switches = 0;
    // full game to OVER, inputs ignored afterwards
    rs(0); e = cyc;
    ex(e, F_SCORE, 0);
    sp(4);
    ex(e + 3999, F_TLS, 2); ex(e + 4004, F_TLS, 1); ex(e + 8000, F_TLS, 1); ex(e + 8004, F_TLS, 0);
    wait_to(e + 20);
    switches[4] = 1;
    ex(e + 21, F_SCORE, 1);
    wait_to(e + 10000);
    sp(6);
    ex(e + 11999, F_LEDR, 'h40); ex(e + 11999, F_STATE, 1); ex(e + 11999, F_TLS, 0);
    ex(e + 12000, F_STATE, 2); ex(e + 12000, F_LEDR, 0); ex(e + 12000, F_SCORE, 1); ex(e + 12000, F_TLS, 0);
    wait_to(e + 12000);
    switches[6] = 1;
    sp(8);
    ex(e + 12003, F_LEDR, 0); ex(e + 12003, F_SCORE, 1); ex(e + 12003, F_STATE, 2);
    ex(e + 12003, F_HCNT, 5); ex(e + 12003, F_ECNT, 2);
    wait_to(e + 12003);
    // restart from OVER, then restart mid-PLAY
    rs(2); e = cyc;
    ex(e, F_STATE, 1); ex(e, F_SCORE, 0); ex(e, F_TLS, 3); ex(e, F_LEDR, 0);
    sp(9);
    wait_to(e + 10);
    switches[9] = 1;
    ex(e + 11, F_SCORE, 1);
    tic(1);
    sp(10);
    wait_to(e + 30);
    ex(e + 30, F_LEDR, 'h400); ex(e + 30, F_TLS, 2);
    rs(2); e = cyc;
    ex(e, F_LEDR, 0); ex(e, F_SCORE, 0); ex(e, F_TLS, 3);
    // out-of-range index, top slot, then edges on empty slots
    ex(e + 1, F_LEDR, 0);
    sp(20);
    ex(e + 2, F_LEDR, 'h20000);
    sp(17);
    wait_to(e + 5);
    switches[17] = 1;
    ex(e + 6, F_SCORE, 1);
    tic(1);
    ex(e + 7, F_LEDR, 'h800);
    sp(11);
    switches[11] = 1;
    ex(e + 8, F_SCORE, 2); ex(e + 8, F_LEDR, 0);
    tic(1);
    switches[13] = 1;
    ex(e + 9, F_SCORE, 2 - PEN);
    tic(1);
    switches[14] = 1; switches[15] = 1;
    ex(e + 10, F_SCORE, PEN ? 0 : 2);
    tic(1);
    tic(5);
    n_chk++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL final state: got 'h%0h, expected 'h1", state);
    end
    n_chk++;
    if (ledr !== '0) begin
      n_fail++;
      $display("FAIL final ledr: got 'h%0h, expected 'h0", ledr);
    end
    n_chk++;
    if (score !== 10'(PEN ? 0 : 2)) begin
      n_fail++;
      $display("FAIL final score: got 'h%0h, expected 'h%0h", score, PEN ? 0 : 2);
    end
    foreach (q[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s never checked at cycle %0d, expected 'h%0h", nm[q[i].fld], q[i].cyc, q[i].val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Central game sequencer for the whack-a-mole design.
- Accepts spawn requests from the mole timing path, owns the 18 mole slots and their lifetimes, detects hits from debounced switches, keeps score, and runs the game clock.
- Sits between the spawn logic (mole control FSM plus LED randomiser) and the LEDR, score and display outputs.

Parameters:
- NUM_MOLES, 18, number of mole slots / LEDs / switches.
- CLKS_PER_MS, 50000, clk cycles per 1 ms tick.
- GAME_MS, 30000, game length in ms.
- SCORE_MAX, 999, score saturation value.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- restart  in  1  single-cycle pulse; starts or restarts a game.
- level  in  2  difficulty; latched at game start.
- spawn_req  in  1  single-cycle request to raise a mole.
- spawn_idx  in  5  target slot for spawn_req.
- switches  in  NUM_MOLES  debounced switch levels.
- ledr  out  NUM_MOLES  mole-up mask.
- score  out  10  current score.
- hit  out  1  pulse: at least one mole hit this cycle.
- expired  out  1  pulse: at least one mole timed out this cycle.
- state  out  2  IDLE=0, PLAY=1, OVER=2.
- time_left_s  out  6  whole seconds remaining.

Behaviour:
- Reset: state=IDLE; ledr, score, hit, expired, time_left_s and all counters are 0.
- ms tick:
  - Internal prescaler counts 0..CLKS_PER_MS-1 and asserts the tick on wrap.
  - Runs only in PLAY; cleared on entering PLAY.
- FSM:
  - IDLE --restart--> PLAY.
  - PLAY --game counter reaches 0 on a tick--> OVER.
  - OVER --restart--> PLAY.
  - PLAY --restart--> PLAY with a full re-init.
  - reset from any state --> IDLE.
- Entering PLAY (registered, same edge as the state change):
  - score=0, ledr=0, game counter=GAME_MS, lifetime table row latched from level.
  - Switch history register loaded with the current switches, so switches already up do not count.
- Spawn (PLAY only):
  - A spawn_req at edge n sets ledr[spawn_idx] at n+1 and loads that slot's lifetime counter.
  - Ignored if spawn_idx >= NUM_MOLES or the slot is already up. No queueing.
- Lifetime: each up slot decrements on every tick. When a counter at 1 receives a tick, the slot clears and expired pulses for one cycle.
- Lifetime per level, in ms (11-bit counters): 0 → 1500, 1 → 1000, 2 → 700, 3 → 400.
- Hit:
  - A rising edge on switches[i] (current=1, history=0) while ledr[i]=1 clears ledr[i] at the next edge.
  - Score increments by the number of hits that cycle, saturating at SCORE_MAX.
  - hit pulses for one cycle.
  - The history register updates every cycle in PLAY.
- Same-cycle collisions on one slot:
  - hit and expiry: hit wins (scored, expired not pulsed for that slot).
  - spawn and hit: the hit resolves against the current ledr and the spawn is ignored.
- time_left_s = game counter / 1000, truncated. It is 0 in IDLE and OVER.
- In OVER and IDLE: ledr=0, spawn and switch inputs ignored, score held until the next restart.
- hit and expired are never asserted outside PLAY.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: a rising switch edge on a slot with ledr[i]=0 during PLAY decrements score by 1 per such slot, saturating at 0. Penalties and hits in the same cycle combine as score + hits - misses, clamped to 0..SCORE_MAX.
- Undefined: edges on empty slots have no effect.

Decomposition:
- Package mole_game_pkg holds:
  - the state enum typedef;
  - the LIFETIME_MS constant array indexed by level;
  - SCORE_W=10 and LIFE_W=11.
- Sub-module mole_slot, instantiated NUM_MOLES times via generate:
  - inputs: clk, reset, init, tick, spawn, hit_edge, lifetime;
  - outputs: up, hit_pulse, expire_pulse.
- Top level holds the FSM, prescaler, game counter, score adder and pulse ORs.

Test Plan:
- Reset then restart with level=0 → state=1, time_left_s=30. spawn_req with idx=5 → ledr=18'h00020 one cycle later. Leave untouched for 1500 ticks → ledr=0 and one expired pulse; score stays 0.
- Level=3, spawn idx=2, raise switches[2] 100 ms later → ledr[2] clears next cycle, hit pulses once, score=1. A second spawn on idx=2 while it is up is ignored (lifetime not reloaded).
- Switches[7] already high at restart, then spawn idx=7 with no new edge → no hit. Toggle switches[7] 0→1 → score=1.
- Same-cycle expiry and hit on slot 0 → score+1 and no expired pulse. Hit on slots 1 and 3 in the same cycle → score+2 with a single hit pulse.
- Run GAME_MS=3000 (bench override) → state=2 at 3000 ticks with ledr=0 and score held. Restart → score=0. Restart mid-PLAY → full re-init. spawn_idx=20 → ignored.
- MISS_PENALTY_EN: score=2, edge on an empty slot → 1; two further edges → stays 0. Without the macro → score unchanged.
